// File: rtl/toggle_bank_pkg.sv
// toggle_bank_pkg: mode encodings and popcount helper shared by the toggle bank
package toggle_bank_pkg;
   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'b00,
      MODE_SET    = 2'b01,
      MODE_CLEAR  = 2'b10,
      MODE_LOAD   = 2'b11
   } mode_t;

   function automatic int popcount(input logic [31:0] v);
      popcount = 0;
      for (int i = 0; i < 32; i++) popcount += int'(v[i]);
   endfunction
endpackage

// File: rtl/toggle_bank_rise_detect.sv
// rise_detect: per-bit 0->1 detector owning the t_prev history register
module rise_detect #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] t,
   output logic [WIDTH-1:0] rise
);
   logic [WIDTH-1:0] t_prev;
   // t is sampled on every edge, reset included, so a bit held across reset release is no edge
   always_ff @(posedge clk) t_prev <= t;
   assign rise = t & ~t_prev;
endmodule

// File: rtl/toggle_bank.sv
// toggle_bank: bank of toggle/set/clear/load flip-flops with change flag and ones count
module toggle_bank
   import toggle_bank_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter bit               EDGE_MODE = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic [WIDTH-1:0]             t,
   input  logic [WIDTH-1:0]             load_data,
   output logic [WIDTH-1:0]             q,
   output logic                         q_changed,
   output logic [$clog2(WIDTH+1)-1:0]   ones_count
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] rise, t_eff, q_next;
   rise_detect #(.WIDTH(WIDTH)) u_rise (.clk, .t, .rise);
   always_comb begin
      t_eff  = EDGE_MODE ? rise : t;
      q_next = !en                ? q :
               mode == MODE_TOGGLE ? q ^ t_eff :
               mode == MODE_SET    ? q | t_eff :
               mode == MODE_CLEAR  ? q & ~t_eff : load_data;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         q          <= RESET_VAL;
         q_changed  <= 1'b0;
         ones_count <= CW'(popcount(32'(RESET_VAL)));
      end else begin
         q          <= q_next;
         q_changed  <= q_next != q;
         ones_count <= CW'(popcount(32'(q_next)));
      end
   end
endmodule

// File: doc/toggle_bank.md
TOGGLE_BANK -- requirements
Module: toggle_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of independent flip-flop channels (1..32).
REQ-002 SHALL have parameter EDGE_MODE, default 1; 1 = act on rising edge of each t bit, 0 = act on level.
REQ-003 SHALL have parameter RESET_VAL, default all zeros, WIDTH-bit value loaded into q on reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock of the block.
REQ-005 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port en  input  1  update enable; 0 = q holds.
REQ-007 SHALL have port mode  input  2  operation select: 00 TOGGLE, 01 SET, 10 CLEAR, 11 LOAD.
REQ-008 SHALL have port t  input  WIDTH  per-channel action request.
REQ-009 SHALL have port load_data  input  WIDTH  value written in LOAD mode.
REQ-010 SHALL have port q  output  WIDTH  registered channel state.
REQ-011 SHALL have port q_changed  output  1  registered; high for one cycle when q took a new value.
REQ-012 SHALL have port ones_count  output  clog2(WIDTH+1)  registered count of 1 bits in q.

Function
REQ-013 SHALL derive t_eff = t & ~t_prev when EDGE_MODE=1, and t_eff = t when EDGE_MODE=0; t_prev is a WIDTH-bit register sampling t every clock.
REQ-014 SHALL update t_prev every non-reset cycle regardless of en or mode.
REQ-015 SHALL, when en=1, compute next q as: TOGGLE q^t_eff; SET q|t_eff; CLEAR q&~t_eff; LOAD load_data (t ignored).
REQ-016 SHALL hold q when en=0; any edges occurring while en=0 are lost, not queued.
REQ-017 SHALL have one-cycle latency: inputs sampled at edge k are reflected in q after edge k.
REQ-018 SHALL assert q_changed in the same cycle the new q is visible iff next q differed from current q; otherwise 0.
REQ-019 SHALL register ones_count from next q so ones_count always matches the q presented alongside it.
REQ-020 SHALL treat multiple t bits asserted together as independent per-channel actions in the same cycle.
REQ-021 SHALL, in EDGE_MODE=1, produce exactly one action per 0->1 transition of a t bit held high for any number of cycles.
REQ-022 SHALL generate no q_changed pulse for a SET on an already-set bit, a CLEAR on an already-clear bit, or a LOAD of the current value.

Reset
REQ-023 SHALL, on reset=1 at a clock edge, set q=RESET_VAL, q_changed=0, ones_count=popcount(RESET_VAL), overriding en, mode and t.
REQ-024 SHALL load t_prev with the current t during reset so a t bit held high across reset release produces no action.
REQ-025 SHALL abandon any in-progress operation on reset mid-stream; the first post-reset update uses only post-reset inputs.

Structure
REQ-026 SHALL place the mode encodings (MODE_TOGGLE, MODE_SET, MODE_CLEAR, MODE_LOAD) in the shared game package.
REQ-027 SHALL implement edge detection in one sub-module, rise_detect, parametrised by WIDTH, owning t_prev and its reset rule.
REQ-028 SHALL keep the q, q_changed and ones_count registers in toggle_bank with no combinational path from inputs to outputs.

Verification
REQ-029 SHALL check: WIDTH=8, EDGE_MODE=1, reset then TOGGLE, t=0x01 held 5 cycles -> q=0x01 once, q_changed pulses once, ones_count=1.
REQ-030 SHALL check: EDGE_MODE=0, TOGGLE, t=0x01 held 4 cycles -> q alternates 0x01,0x00,0x01,0x00 with q_changed high each cycle.
REQ-031 SHALL check: q=0x0F, SET t=0x03 -> q=0x0F, q_changed=0; then CLEAR t=0x81 (edges) -> q=0x0E, ones_count=3, q_changed=1.
REQ-032 SHALL check: LOAD load_data=0xA5 with en=1 -> q=0xA5, ones_count=4 next cycle; same with en=0 -> q unchanged.
REQ-033 SHALL check: t=0xFF held high while reset asserted then released, EDGE_MODE=1 -> q stays RESET_VAL, no q_changed.
REQ-034 SHALL check: reset asserted cycle after LOAD 0xFF -> q=RESET_VAL, q_changed=0, ones_count=popcount(RESET_VAL) the following cycle.
